// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the asynchronous FIFO read-side streamer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int SKID_DEPTH_MIN = 2;
    localparam int SKID_DEPTH_MAX = 8;

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular skid buffer: one push and one pop per cycle, head shown combinationally.
module fifo_skid_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int SKID_DEPTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              push_data,
    input  logic                               pop,
    output logic [$clog2(SKID_DEPTH+1)-1:0]    cnt,
    output logic [DATA_WIDTH-1:0]              head
);

    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         cnt_q;

    // Pointers wrap at SKID_DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) cnt_q <= cnt_q + CW'(1);
            else if (!push && pop) cnt_q <= cnt_q - CW'(1);
        end
    end

    // The upstream issue rule reserves space for every returning word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && cnt_q == CW'(SKID_DEPTH)));
            assert (!(pop && cnt_q == '0));
        end
    end

    assign cnt  = cnt_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-domain engine: pulls words from the async FIFO and re-presents them on a
// valid/ready stream (m_valid && m_ready = transfer; m_data held while stalled).
module fifo_read_streamer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SKID_DEPTH = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  busy,
    output state_t                state_dbg
);

    localparam int CW = $clog2(SKID_DEPTH + 1);

    if (SKID_DEPTH < SKID_DEPTH_MIN || SKID_DEPTH > SKID_DEPTH_MAX) begin : g_bad_depth
        $error("fifo_read_streamer: SKID_DEPTH out of range");
    end

    state_t               state_q, state_d;
    logic                 pend_q;
    logic [CNT_WIDTH-1:0] word_cnt_q;
    logic [CW-1:0]        skid_cnt;
    logic [CW:0]          occupancy;
    logic                 handshake;

    // Words already in the skid plus the one returning this cycle; m_ready is
    // deliberately absent so there is no ready -> r_en path.
    assign occupancy = {1'b0, skid_cnt} + {{CW{1'b0}}, pend_q};
    assign r_en      = !rrst && (state_q == RUN) && !empty
                       && (occupancy < (CW+1)'(SKID_DEPTH));
    assign m_valid   = (skid_cnt != '0);
    assign handshake = m_valid && m_ready;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (pend_q),
        .push_data (fifo_rdata),
        .pop       (handshake),
        .cnt       (skid_cnt),
        .head      (m_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = STOP;
            STOP: begin
                if (!pend_q)     state_d = IDLE;
                else if (enable) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= r_en;
            if (handshake) word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign word_cnt  = word_cnt_q;
    assign busy      = (state_q != IDLE) || m_valid;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Self-checking bench for fifo_read_streamer against a queue-order FIFO model.
module tb_fifo_read_streamer;
    import fifo_rd_pkg::*;

    localparam int DW    = 8;
    localparam int SD    = 3;
    localparam int CW    = 4;
    localparam int MEMSZ = 1024;

    logic          rclk = 1'b0;
    logic          rrst, enable, m_ready;
    logic          empty, r_en, m_valid, busy;
    logic [DW-1:0] fifo_rdata = '0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_cnt;
    state_t        state_dbg;

    int total = 0;
    int bad   = 0;

    // FIFO model: words in write order; data appears the cycle after r_en.
    logic [DW-1:0] fifo_mem [MEMSZ];
    int            wr_idx = 0;
    int            rd_idx = 0;
    logic          force_empty = 1'b0;

    // Monitor records, consumed by the test tasks.
    logic [DW-1:0] got_mem [MEMSZ];
    int            got_n = 0, ren_total = 0, ren_viol = 0, stall_viol = 0, cnt_viol = 0;
    int            mon_cnt = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] stall_data = '0;

    // Scoreboard positions: next delivered word to check and its FIFO index.
    int got_rd = 0;
    int exp_rd = 0;

    always #5 rclk = ~rclk;

    assign empty = force_empty || (rd_idx == wr_idx);

    fifo_read_streamer #(
        .DATA_WIDTH (DW),
        .SKID_DEPTH (SD),
        .CNT_WIDTH  (CW)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .enable     (enable),
        .empty      (empty),
        .fifo_rdata (fifo_rdata),
        .r_en       (r_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    always @(posedge rclk) begin
        if (r_en) begin
            fifo_rdata <= fifo_mem[rd_idx % MEMSZ];
            rd_idx     <= rd_idx + 1;
        end
    end

    always @(negedge rclk) begin
        if (rrst) begin
            mon_cnt <= 0;
            stalled <= 1'b0;
        end else begin
            if (r_en) ren_total <= ren_total + 1;
            if (r_en && empty) ren_viol <= ren_viol + 1;
            if (word_cnt !== CW'(mon_cnt)) cnt_viol <= cnt_viol + 1;
            if (stalled && (!m_valid || m_data !== stall_data)) stall_viol <= stall_viol + 1;
            if (m_valid && m_ready) begin
                got_mem[got_n % MEMSZ] <= m_data;
                got_n   <= got_n + 1;
                mon_cnt <= (mon_cnt + 1) % (1 << CW);
            end
            stalled    <= m_valid && !m_ready;
            stall_data <= m_data;
        end
    end

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rrst = 1'b1;
        repeat (n) step();
        rrst = 1'b0;
        got_rd = got_n;
        exp_rd = rd_idx;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fifo_mem[wr_idx % MEMSZ] = d;
        wr_idx++;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int quiet;
        quiet = 0;
        ok    = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge rclk);
            if (rd_idx == wr_idx && !m_valid && !r_en) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        bit ok;
        rrst = 1'b1; enable = 1'b1; m_ready = 1'b1; force_empty = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        for (int c = 0; c < 3; c++) begin
            @(negedge rclk);
            total++;
            if (r_en !== 1'b0 || m_valid !== 1'b0 || word_cnt !== '0 || busy !== 1'b0 || m_data !== '0) begin
                bad++;
                $display("FAIL reset_outputs c=%0d: r_en=%b m_valid=%b word_cnt=%0d busy=%b m_data=%h, want all 0",
                         c, r_en, m_valid, word_cnt, busy, m_data);
            end
        end
        step();
        rrst = 1'b0;
        got_rd = got_n;
        exp_rd = 0;
        wait_drain(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL reset_drain_timeout: rd_idx=%0d wr_idx=%0d", rd_idx, wr_idx); end
        while (got_rd < got_n) begin
            total++;
            if (got_mem[got_rd % MEMSZ] !== fifo_mem[exp_rd % MEMSZ]) begin
                bad++;
                $display("FAIL reset_order: got %h want %h", got_mem[got_rd % MEMSZ], fifo_mem[exp_rd % MEMSZ]);
            end
            got_rd++; exp_rd++;
        end
        total++;
        if (exp_rd != wr_idx || word_cnt !== CW'(2)) begin
            bad++;
            $display("FAIL reset_post_count: delivered_to=%0d word_cnt=%0d, want %0d and 2", exp_rd, word_cnt, wr_idx);
        end
        enable = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_streaming();
        int  first_ren, last_ren, n_ren, first_mv, last_mv, n_mv;
        bit  ok;
        first_ren = -1; last_ren = -1; n_ren = 0;
        first_mv  = -1; last_mv  = -1; n_mv  = 0;
        enable = 1'b0; m_ready = 1'b1;
        do_reset(2);
        for (int i = 0; i < 8; i++) push_word(8'hA0 + DW'(i));
        step();
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            if (r_en) begin
                if (first_ren < 0) first_ren = c;
                last_ren = c; n_ren++;
            end
            if (m_valid) begin
                if (first_mv < 0) first_mv = c;
                last_mv = c; n_mv++;
            end
        end
        step();
        total++;
        if (n_ren != 8 || last_ren - first_ren != 7) begin
            bad++; $display("FAIL stream_ren_burst: count=%0d span=%0d, want 8 and 7", n_ren, last_ren - first_ren);
        end
        total++;
        if (first_mv - first_ren != 2) begin
            bad++; $display("FAIL stream_latency: %0d cycles, want 2", first_mv - first_ren);
        end
        total++;
        if (n_mv != 8 || last_mv - first_mv != 7) begin
            bad++; $display("FAIL stream_valid_run: count=%0d span=%0d, want 8 and 7", n_mv, last_mv - first_mv);
        end
        while (got_rd < got_n) begin
            total++;
            if (got_mem[got_rd % MEMSZ] !== fifo_mem[exp_rd % MEMSZ]) begin
                bad++;
                $display("FAIL stream_order: got %h want %h", got_mem[got_rd % MEMSZ], fifo_mem[exp_rd % MEMSZ]);
            end
            got_rd++; exp_rd++;
        end
        total++;
        if (exp_rd != wr_idx || word_cnt !== CW'(8)) begin
            bad++; $display("FAIL stream_count: delivered_to=%0d word_cnt=%0d, want %0d and 8", exp_rd, word_cnt, wr_idx);
        end
        enable = 1'b0;
        wait_drain(30, ok);
    endtask

    task automatic test_backpressure();
        int ren0, sv0;
        bit ok;
        enable = 1'b0; m_ready = 1'b0;
        do_reset(2);
        for (int i = 0; i < 5; i++) push_word(DW'($urandom_range(0, 255)));
        step();
        ren0 = ren_total; sv0 = stall_viol;
        enable = 1'b1;
        repeat (12) @(negedge rclk);
        total++;
        if (ren_total - ren0 != SD) begin
            bad++; $display("FAIL bp_ren_pulses: got %0d want %0d", ren_total - ren0, SD);
        end
        total++;
        if (r_en !== 1'b0 || m_valid !== 1'b1) begin
            bad++; $display("FAIL bp_hold: r_en=%b m_valid=%b, want 0 and 1", r_en, m_valid);
        end
        total++;
        if (m_data !== fifo_mem[exp_rd % MEMSZ]) begin
            bad++; $display("FAIL bp_head: got %h want %h", m_data, fifo_mem[exp_rd % MEMSZ]);
        end
        step();
        m_ready = 1'b1;
        wait_drain(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_drain_timeout: rd_idx=%0d wr_idx=%0d", rd_idx, wr_idx); end
        total++;
        if (stall_viol != sv0) begin
            bad++; $display("FAIL bp_stable: %0d stall changes, want 0", stall_viol - sv0);
        end
        while (got_rd < got_n) begin
            total++;
            if (got_mem[got_rd % MEMSZ] !== fifo_mem[exp_rd % MEMSZ]) begin
                bad++;
                $display("FAIL bp_order: got %h want %h", got_mem[got_rd % MEMSZ], fifo_mem[exp_rd % MEMSZ]);
            end
            got_rd++; exp_rd++;
        end
        total++;
        if (exp_rd != wr_idx || word_cnt !== CW'(5)) begin
            bad++; $display("FAIL bp_count: delivered_to=%0d word_cnt=%0d, want %0d and 5", exp_rd, word_cnt, wr_idx);
        end
        enable = 1'b0;
        wait_drain(30, ok);
    endtask

    task automatic test_empty_boundary();
        int  g0, rv0, sv0;
        bit  ok;
        enable = 1'b0; m_ready = 1'b1;
        do_reset(2);
        g0 = got_n; rv0 = ren_viol; sv0 = stall_viol;
        for (int i = 0; i < 12; i++) push_word(DW'($urandom_range(0, 255)));
        enable = 1'b1;
        for (int c = 0; c < 300 && (got_n - g0) < 12; c++) begin
            step();
            force_empty = ~force_empty;
            m_ready     = 1'($urandom_range(0, 1));
        end
        force_empty = 1'b0; m_ready = 1'b1;
        wait_drain(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL empty_drain_timeout: rd_idx=%0d wr_idx=%0d", rd_idx, wr_idx); end
        total++;
        if (ren_viol != rv0) begin
            bad++; $display("FAIL empty_ren: %0d reads while empty, want 0", ren_viol - rv0);
        end
        total++;
        if (stall_viol != sv0) begin
            bad++; $display("FAIL empty_stable: %0d stall changes, want 0", stall_viol - sv0);
        end
        while (got_rd < got_n) begin
            total++;
            if (got_mem[got_rd % MEMSZ] !== fifo_mem[exp_rd % MEMSZ]) begin
                bad++;
                $display("FAIL empty_order: got %h want %h", got_mem[got_rd % MEMSZ], fifo_mem[exp_rd % MEMSZ]);
            end
            got_rd++; exp_rd++;
        end
        total++;
        if (exp_rd != wr_idx || word_cnt !== CW'(12)) begin
            bad++; $display("FAIL empty_count: delivered_to=%0d word_cnt=%0d, want %0d and 12", exp_rd, word_cnt, wr_idx);
        end
        enable = 1'b0;
        wait_drain(30, ok);
    endtask

    task automatic test_stop_resume();
        int  rd0, g0, rd_stop, idle_at, stop_ren;
        bit  found, saw_stop, ok;
        found = 1'b0; saw_stop = 1'b0; idle_at = -1; stop_ren = 0;
        enable = 1'b0; m_ready = 1'b1;
        do_reset(2);
        rd0 = rd_idx; g0 = got_n;
        for (int i = 0; i < 6; i++) push_word(DW'($urandom_range(0, 255)));
        step();
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (r_en) begin found = 1'b1; break; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL stop_no_ren: r_en=%b want 1 within 20 cycles", r_en); end
        enable  = 1'b0;
        rd_stop = rd_idx + 1;
        @(negedge rclk);
        total++;
        if (r_en !== 1'b1) begin bad++; $display("FAIL stop_same_cycle_ren: r_en=%b want 1", r_en); end
        for (int c = 1; c <= 4 && idle_at < 0; c++) begin
            @(negedge rclk);
            if (state_dbg == STOP) saw_stop = 1'b1;
            if (state_dbg == STOP && r_en) stop_ren++;
            if (state_dbg == IDLE) idle_at = c;
        end
        total++;
        if (!saw_stop || idle_at < 0 || idle_at > 3 || stop_ren != 0) begin
            bad++;
            $display("FAIL stop_to_idle: saw_stop=%b idle_at=%0d stop_ren=%0d, want 1, 1..3, 0", saw_stop, idle_at, stop_ren);
        end
        repeat (4) step();
        total++;
        if (rd_idx != rd_stop || (got_n - g0) != (rd_stop - rd0)) begin
            bad++;
            $display("FAIL stop_inflight: reads=%0d delivered=%0d, want %0d and %0d",
                     rd_idx - rd0, got_n - g0, rd_stop - rd0, rd_stop - rd0);
        end
        enable = 1'b1;
        wait_drain(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL resume_timeout: rd_idx=%0d wr_idx=%0d", rd_idx, wr_idx); end
        while (got_rd < got_n) begin
            total++;
            if (got_mem[got_rd % MEMSZ] !== fifo_mem[exp_rd % MEMSZ]) begin
                bad++;
                $display("FAIL resume_order: got %h want %h", got_mem[got_rd % MEMSZ], fifo_mem[exp_rd % MEMSZ]);
            end
            got_rd++; exp_rd++;
        end
        total++;
        if (exp_rd != wr_idx || word_cnt !== CW'(6)) begin
            bad++; $display("FAIL resume_count: delivered_to=%0d word_cnt=%0d, want %0d and 6", exp_rd, word_cnt, wr_idx);
        end
        enable = 1'b0;
        wait_drain(30, ok);
    endtask

    task automatic test_wrap_and_reset();
        int  g0, left;
        bit  ok;
        enable = 1'b0; m_ready = 1'b1;
        do_reset(2);
        for (int i = 0; i < 17; i++) push_word(DW'($urandom_range(0, 255)));
        enable = 1'b1;
        wait_drain(100, ok);
        total++;
        if (!ok || word_cnt !== CW'(17 % (1 << CW))) begin
            bad++; $display("FAIL wrap_count: ok=%b word_cnt=%0d, want 1 and %0d", ok, word_cnt, 17 % (1 << CW));
        end
        g0 = got_n;
        for (int i = 0; i < 10; i++) push_word(DW'($urandom_range(0, 255)));
        for (int c = 0; c < 40 && (got_n - g0) < 3; c++) step();
        rrst = 1'b1;
        @(negedge rclk);
        total++;
        if (r_en !== 1'b0) begin bad++; $display("FAIL midreset_ren: r_en=%b want 0", r_en); end
        step();
        rrst = 1'b0;
        @(negedge rclk);
        total++;
        if (m_valid !== 1'b0 || word_cnt !== '0 || busy !== 1'b0 || r_en !== 1'b0
            || m_data !== '0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL midreset_outputs: m_valid=%b word_cnt=%0d busy=%b r_en=%b m_data=%h state=%0d, want reset values",
                     m_valid, word_cnt, busy, r_en, m_data, state_dbg);
        end
        while (got_rd < got_n) begin
            total++;
            if (got_mem[got_rd % MEMSZ] !== fifo_mem[exp_rd % MEMSZ]) begin
                bad++;
                $display("FAIL prereset_order: got %h want %h", got_mem[got_rd % MEMSZ], fifo_mem[exp_rd % MEMSZ]);
            end
            got_rd++; exp_rd++;
        end
        // Words read but not yet delivered when reset hit are discarded.
        exp_rd = rd_idx;
        left   = wr_idx - rd_idx;
        wait_drain(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL postreset_timeout: rd_idx=%0d wr_idx=%0d", rd_idx, wr_idx); end
        while (got_rd < got_n) begin
            total++;
            if (got_mem[got_rd % MEMSZ] !== fifo_mem[exp_rd % MEMSZ]) begin
                bad++;
                $display("FAIL postreset_order: got %h want %h", got_mem[got_rd % MEMSZ], fifo_mem[exp_rd % MEMSZ]);
            end
            got_rd++; exp_rd++;
        end
        total++;
        if (exp_rd != wr_idx || word_cnt !== CW'(left % (1 << CW))) begin
            bad++;
            $display("FAIL postreset_count: delivered_to=%0d word_cnt=%0d, want %0d and %0d",
                     exp_rd, word_cnt, wr_idx, left % (1 << CW));
        end
        enable = 1'b0;
        wait_drain(30, ok);
    endtask

    initial begin
        rrst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_stop_resume();
        test_wrap_and_reset();
        total++;
        if (cnt_viol != 0) begin
            bad++; $display("FAIL word_cnt_track: %0d cycles off the handshake count", cnt_viol);
        end
        total++;
        if (ren_viol != 0) begin
            bad++; $display("FAIL ren_while_empty: %0d occurrences, want 0", ren_viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
